barrel_unrotator_pipe: RTL and testbench
========================================

// Module: barrel_unrotator_pipe
// PURPOSE
//  Inverse of the 8-bit rotate-right barrel shifter: rotates a word LEFT by amt,
//  so unrot(rot_right(d,c),c) == d. Same W-bit datapath, but as a log2(W)-stage
//  elastic pipeline with valid/ready handshakes on both sides. It sits on the
//  receive/decode side of the rotate path and restores the original word order.
// PARAMETERS
//  W      8              data width; power of two, >= 2
//  AMT_W  $clog2(W) = 3  rotate-amount width, derived; never overridden
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input word and amount are valid
//  in_ready   out  1      block accepts the input this cycle
//  in_data    in   W      rotated word
//  in_amt     in   AMT_W  rotate amount (0..W-1)
//  out_valid  out  1      out_data is valid
//  out_ready  in   1      downstream accepts out_data
//  out_data   out  W      out_data[i] = in_data[(i - in_amt) mod W]
//  in_par     in   1      even parity of in_data; present only with UNROT_PARITY_EN
//  out_perr   out  1      parity mismatch flag; present only with UNROT_PARITY_EN
// BEHAVIOUR
//  - Stage k (k = 0..AMT_W-1) rotates left by 2**k when amt[k]=1, else passes through.
//    Each stage has registers for valid, data and the remaining amt bits.
//  - Transfer occurs when valid && ready are high on the same clk edge. Latency is AMT_W
//    cycles (3 for W=8) from input acceptance to out_valid. Throughput is 1 word/cycle.
//  - Stage k loads when its slot is empty or its own output advances this cycle.
//    in_ready = stage0 empty || stage0 advances (bubbles collapse).
//    in_ready must not depend combinationally on in_valid.
//  - When out_ready=0 and out_valid=1, out_data, out_valid and out_perr stay stable.
//    Upstream stages keep filling until the pipe is full. After that, in_ready=0.
//  - amt=0 gives pass-through. Full wrap-around: bits leaving at MSB re-enter at LSB.
//    amt is unsigned, so there are no out-of-range amounts.
//  - Reset: all stage valids=0, so out_valid=0 and in_ready=1 one cycle after rst_n
//    deasserts. Data registers clear to 0 and out_perr=0. A reset asserted mid-stream
//    drops every in-flight word immediately (async clear). No partial output is produced.
//  - Accept and emit on the same cycle are legal, including when the pipe is full.
//  - No FSM. State is only the valid bits per stage.
// CONFIGURATION
//  UNROT_PARITY_EN defined:
//   - in_par travels with the word through every stage.
//   - At the output, out_perr = ^out_data ^ par_carried (rotation preserves parity).
//   - out_perr is qualified by out_valid and holds under stall.
//  UNROT_PARITY_EN undefined:
//   - in_par and out_perr ports and their registers do not exist.
//   - Datapath and timing are otherwise identical.
// STRUCTURE
//  - Shared package barrel_pkg:
//    - BARREL_W = 8 and BARREL_AMT_W = 3 constants.
//    - typedefs word_t and amt_t.
//    - function rotl(word_t, int sh), also used by the bench as the reference model.
//  - Sub-module unrot_stage #(W, SHIFT):
//    - one valid/ready register slice that conditionally rotates left by SHIFT.
//    - Instantiated AMT_W times with SHIFT = 1, 2, 4 by a generate loop.
//  - The top level only chains the stages and holds the optional parity logic.
// TESTING
//  1. in_data=8'hC0, amt=1, out_ready=1 -> out_data=8'h81, 3 cycles after acceptance.
//  2. amt=0, in_data=8'hA5 -> 8'hA5; amt=4, 8'h12 -> 8'h21; amt=7, 8'h01 -> 8'h80.
//  3. Round trip: 256 data values x 8 amounts through the rotate-right shifter then
//     this block -> output equals the original every time. Streamed back-to-back,
//     in_valid held high -> one result per cycle.
//  4. Hold out_ready=0 for 10 cycles while feeding -> pipe fills, in_ready=0 after 3
//     accepts, out_data stable. On release, results drain in order with no loss or duplicate.
//  5. Assert rst_n=0 with 3 words in flight -> out_valid=0 immediately.
//     After release, the next word is processed cleanly.
//  6. (UNROT_PARITY_EN) in_data=8'h03, in_par=0 -> out_perr=0;
//     same word with in_par=1 -> out_perr=1 with its output word.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared constants, word/amount types and the rotate-left helper for the barrel rotate path.
package barrel_pkg;
  localparam int BARREL_W     = 8;
  localparam int BARREL_AMT_W = $clog2(BARREL_W);

  typedef logic [BARREL_W-1:0]     word_t;
  typedef logic [BARREL_AMT_W-1:0] amt_t;

  // Rotate left by sh (any integer, reduced mod BARREL_W); bits leaving the MSB re-enter at the LSB.
  function automatic word_t rotl(word_t d, int sh);
    int s;
    s = ((sh % BARREL_W) + BARREL_W) % BARREL_W;
    return word_t'((d << s) | (d >> (BARREL_W - s)));
  endfunction
endpackage

// File: rtl/unrot_stage.sv
// One elastic valid/ready register slice that rotates left by SHIFT when amt[0] is set.
// The amount is consumed LSB-first; the remaining bits travel down shifted right by one.
// UNROT_PARITY_EN adds a parity bit that rides along with the word.
module unrot_stage
  import barrel_pkg::*;
#(
  parameter int W     = BARREL_W,
  parameter int SHIFT = 1,
  parameter int AMT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic [AMT_W-1:0] in_amt_i,
`ifdef UNROT_PARITY_EN
  input  logic             in_par_i,
  output logic             out_par_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic [AMT_W-1:0] out_amt_o
);
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             load;

  // Ready depends only on this slot and downstream, never on in_valid.
  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_amt_i[0] ? {in_data_i[W-1-SHIFT:0], in_data_i[W-1:W-SHIFT]} : in_data_i;
      amt_d   = in_amt_i >> 1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
    end
  end

`ifdef UNROT_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par_q <= 1'b0;
    else if (load) par_q <= in_par_i;
  end
  assign out_par_o = par_q;
`endif

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_amt_o   = amt_q;
endmodule

// File: rtl/barrel_unrotator_pipe.sv
// Elastic log2(W)-stage rotate-left pipeline undoing the rotate-right shifter.
// Optional feature macro: UNROT_PARITY_EN (carries in_par, flags out_perr).
module barrel_unrotator_pipe
  import barrel_pkg::*;
#(
  parameter  int W     = BARREL_W,
  localparam int AMT_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [AMT_W-1:0] in_amt,
`ifdef UNROT_PARITY_EN
  input  logic             in_par,
  output logic             out_perr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data
);
  // Index k is the boundary feeding stage k; index AMT_W is the pipe output.
  logic [AMT_W:0]            vld_pipe;
  logic [AMT_W:0]            rdy_pipe;
  logic [AMT_W:0][W-1:0]     data_pipe;
  logic [AMT_W:0][AMT_W-1:0] amt_pipe;
`ifdef UNROT_PARITY_EN
  logic [AMT_W:0]            par_pipe;
  assign par_pipe[0] = in_par;
`endif

  assign vld_pipe[0]      = in_valid;
  assign data_pipe[0]     = in_data;
  assign amt_pipe[0]      = in_amt;
  assign in_ready         = rdy_pipe[0];
  assign rdy_pipe[AMT_W]  = out_ready;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    unrot_stage #(.W(W), .SHIFT(1 << k), .AMT_W(AMT_W)) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (vld_pipe[k]),
      .in_ready_o  (rdy_pipe[k]),
      .in_data_i   (data_pipe[k]),
      .in_amt_i    (amt_pipe[k]),
`ifdef UNROT_PARITY_EN
      .in_par_i    (par_pipe[k]),
      .out_par_o   (par_pipe[k+1]),
`endif
      .out_valid_o (vld_pipe[k+1]),
      .out_ready_i (rdy_pipe[k+1]),
      .out_data_o  (data_pipe[k+1]),
      .out_amt_o   (amt_pipe[k+1])
    );
  end

  // Every amount bit has been consumed by the last stage.
  logic unused_amt;
  assign unused_amt = ^amt_pipe[AMT_W];

  assign out_valid = vld_pipe[AMT_W];
  assign out_data  = data_pipe[AMT_W];

`ifdef UNROT_PARITY_EN
  // Rotation preserves parity, so any difference is a carried-bit or datapath error.
  assign out_perr = out_valid & (^out_data ^ par_pipe[AMT_W]);
`endif
endmodule

// File: tb/tb_barrel_unrotator_pipe.sv
// Scoreboard bench for barrel_unrotator_pipe; covers UNROT_PARITY_EN when defined.
module tb_barrel_unrotator_pipe;
  import barrel_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  word_t in_data = '0;
  amt_t  in_amt = '0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  word_t out_data;
`ifdef UNROT_PARITY_EN
  logic  in_par = 1'b0;
  logic  out_perr;
  bit    exp_perr_q[$];
  bit    obs_perr_q[$];
`endif

  word_t exp_q[$];
  word_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    acc;

  always #5 clk = ~clk;

  barrel_unrotator_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
`ifdef UNROT_PARITY_EN
    .in_par   (in_par),
    .out_perr (out_perr),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  function automatic word_t rotr(word_t d, int s);
    return word_t'((d >> s) | (d << (BARREL_W - s)));
  endfunction

  // Called at a negedge with inputs already driven; records the handshakes of the coming posedge.
  task automatic tick();
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      obs_q.push_back(out_data);
`ifdef UNROT_PARITY_EN
      obs_perr_q.push_back(out_perr);
`endif
    end
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
`ifdef UNROT_PARITY_EN
    exp_perr_q.delete();
    obs_perr_q.delete();
`endif
  endtask

  task automatic flush(output bit to);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && n < 50) begin
      tick();
      n++;
    end
    to = (obs_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_latency();
    int lat;
    clear_q();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_data = 8'hC0; in_amt = 3'd1;
    tick();
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL latency_accept got %b want 1", acc); end
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL latency_cycles got %0d want 3", lat); end
    checks++; if (out_data !== 8'h81) begin errors++; $display("FAIL latency_data got %h want 81", out_data); end
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_directed();
    word_t din[3];
    amt_t  ain[3];
    word_t dexp[3];
    word_t e, o;
    bit    to;
    din  = '{8'hA5, 8'h12, 8'h01};
    ain  = '{3'd0, 3'd4, 3'd7};
    dexp = '{8'hA5, 8'h21, 8'h80};
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = din[i]; in_amt = ain[i];
      tick();
      if (acc) exp_q.push_back(dexp[i]);
    end
    checks++; if (exp_q.size() != 3) begin errors++; $display("FAIL directed_accepts got %0d want 3", exp_q.size()); end
    flush(to);
    checks++; if (to) begin errors++; $display("FAIL directed_timeout got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL directed_data got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    int    stalls;
    word_t e, o;
    bit    to;
    clear_q();
    stalls    = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int a = 0; a < 8; a++) begin
      for (int d = 0; d < 256; d++) begin
        in_data = rotr(word_t'(d), a);
        in_amt  = amt_t'(a);
        tick();
        if (acc) exp_q.push_back(word_t'(d));
        else     stalls++;
      end
    end
    in_valid = 1'b0;
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_input_stalls got %0d want 0", stalls); end
    checks++; if (obs_q.size() != 2045) begin errors++; $display("FAIL b2b_output_rate got %0d want 2045", obs_q.size()); end
    flush(to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d words want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_roundtrip got %h want %h", o, e); end
    end
  endtask

  task automatic test_stall();
    word_t sd[6];
    amt_t  sa[6];
    word_t held, e, o;
    bit    have, unstable, to;
    int    idx, n;
    sd = '{8'h96, 8'h3C, 8'h01, 8'hF0, 8'h5A, 8'h81};
    sa = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    clear_q();
    idx = 0; have = 1'b0; unstable = 1'b0; held = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = sd[idx]; in_amt = sa[idx];
      tick();
      if (acc) begin exp_q.push_back(rotl(sd[idx], int'(sa[idx]))); idx++; end
      if (out_valid) begin
        if (!have) begin have = 1'b1; held = out_data; end
        else if (out_data !== held) unstable = 1'b1;
      end else if (have) unstable = 1'b1;
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL stall_accepts got %0d want 3", idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    checks++; if (unstable || !have) begin errors++; $display("FAIL stall_hold got unstable=%b seen=%b want 0 1", unstable, have); end
    checks++; if (held !== rotl(sd[0], int'(sa[0]))) begin errors++; $display("FAIL stall_head got %h want %h", held, rotl(sd[0], int'(sa[0]))); end
    out_ready = 1'b1;
    n = 0;
    while (idx < 6 && n < 20) begin
      in_valid = 1'b1; in_data = sd[idx]; in_amt = sa[idx];
      tick();
      if (acc) begin exp_q.push_back(rotl(sd[idx], int'(sa[idx]))); idx++; end
      n++;
    end
    flush(to);
    checks++; if (to || exp_q.size() != 6) begin errors++; $display("FAIL stall_drain got %0d of %0d words want 6", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_order got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    word_t e, o;
    bit    to;
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = word_t'(8'h11 * (i + 1)); in_amt = 3'd1;
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_inflight got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_q();
    in_valid = 1'b1; in_data = 8'h5A; in_amt = 3'd3;
    tick();
    if (acc) exp_q.push_back(8'hD2);
    flush(to);
    checks++; if (to || obs_q.size() != 1) begin errors++; $display("FAIL midrst_count got %0d want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL midrst_data got %h want %h", o, e); end
    end
  endtask

`ifdef UNROT_PARITY_EN
  task automatic test_parity();
    word_t e, o;
    bit    pe, po, to;
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h03; in_amt = 3'd2; in_par = 1'b0;
    tick();
    if (acc) begin exp_q.push_back(8'h0C); exp_perr_q.push_back(1'b0); end
    in_par = 1'b1;
    tick();
    if (acc) begin exp_q.push_back(8'h0C); exp_perr_q.push_back(1'b1); end
    in_par = 1'b0;
    flush(to);
    checks++; if (to || exp_q.size() != 2) begin errors++; $display("FAIL parity_count got %0d of %0d want 2", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      pe = exp_perr_q.pop_front(); po = obs_perr_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL parity_data got %h want %h", o, e); end
      checks++; if (po !== pe) begin errors++; $display("FAIL parity_perr got %b want %b", po, pe); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef UNROT_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
